fft_input_reorder: RTL and testbench

Input stage of the radix-2 FFT datapath. It accepts one packed complex sample per handshake in natural order, stores a full frame in bit-reversed address order, then issues the first-stage butterfly operand pairs (A, B) in sequence. Its pair outputs drive the butterfly's `fft_input_A` and `fft_input_B` directly. Samples pass through bit-exact; the block does no arithmetic on them.

---
 rtl/fft_input_reorder.sv | 172 +++++++++++++++++
 tb/tb_fft_input_reorder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_reorder.sv
// fft_input_reorder: gathers a natural-order frame into bit-reversed
// storage, then issues first-stage radix-2 butterfly operand pairs.
//
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : sample handshake, in_data = x[n] in order
//   pair_valid/pair_ready : pair handshake
//   pair_a, pair_b        : operands mem[2k], mem[2k+1]
//   pair_idx              : pair index k
//   frame_done            : pulse after the last pair of a frame
module fft_input_reorder #(
  parameter int N      = 8,
  parameter int LOG2N  = 3,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [DATA_W-1:0] pair_a,
  output logic [DATA_W-1:0] pair_b,
  output logic [LOG2N-2:0]  pair_idx,
  output logic              frame_done
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [LOG2N-1:0] W_LAST = (LOG2N)'(N - 1);
  localparam logic [LOG2N-1:0] W_ONE  = (LOG2N)'(1);
  localparam logic [LOG2N-2:0] K_LAST = (LOG2N-1)'(N/2 - 1);
  localparam logic [LOG2N-2:0] K_ONE  = (LOG2N-1)'(1);

  state_t             state_q, state_d;
  logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LOG2N-2:0]   k_q, k_d;
  logic               rdy_q, rdy_d;
  logic               pv_q, pv_d;
  logic               fd_q, fd_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;

  logic [DATA_W-1:0]  mem [N];

  logic               wr_en;
  logic [LOG2N-1:0]   wr_addr;
  logic [LOG2N-2:0]   rd_k;
  logic [LOG2N-1:0]   rd_a_addr;
  logic [LOG2N-1:0]   rd_b_addr;
  logic [DATA_W-1:0]  rd_a;
  logic [DATA_W-1:0]  rd_b;
  logic               in_fire;
  logic               pair_fire;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] v
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_fire   = in_valid && rdy_q;
  assign pair_fire = pv_q && pair_ready;

  assign wr_en   = in_fire && (state_q == FILL);
  assign wr_addr = bitrev(wr_cnt_q);

  // Next pair to load: pair 0 on the fill->drain edge,
  // otherwise the one after the pair being accepted.
  assign rd_k      = (state_q == FILL) ? '0 : k_q + K_ONE;
  assign rd_a_addr = {rd_k, 1'b0};
  assign rd_b_addr = {rd_k, 1'b1};

  // Forward the sample written on the same edge a pair is loaded.
  assign rd_a = (wr_en && (wr_addr == rd_a_addr)) ?
                in_data : mem[rd_a_addr];
  assign rd_b = (wr_en && (wr_addr == rd_b_addr)) ?
                in_data : mem[rd_b_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      k_q      <= '0;
      rdy_q    <= 1'b0;
      pv_q     <= 1'b0;
      fd_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      k_q      <= k_d;
      rdy_q    <= rdy_d;
      pv_q     <= pv_d;
      fd_q     <= fd_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    k_d      = k_q;
    rdy_d    = rdy_q;
    pv_d     = pv_q;
    fd_d     = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      FILL: begin
        rdy_d = 1'b1;
        pv_d  = 1'b0;
        if (in_fire) begin
          if (wr_cnt_q == W_LAST) begin
            wr_cnt_d = '0;
            state_d  = DRAIN;
            rdy_d    = 1'b0;
            pv_d     = 1'b1;
            k_d      = '0;
            a_d      = rd_a;
            b_d      = rd_b;
          end else begin
            wr_cnt_d = wr_cnt_q + W_ONE;
          end
        end
      end
      DRAIN: begin
        rdy_d = 1'b0;
        if (pair_fire) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = FILL;
            pv_d    = 1'b0;
            fd_d    = 1'b1;
            rdy_d   = 1'b1;
          end else begin
            k_d = k_q + K_ONE;
            a_d = rd_a;
            b_d = rd_b;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign in_ready   = rdy_q;
  assign pair_valid = pv_q;
  assign pair_a     = a_q;
  assign pair_b     = b_q;
  assign pair_idx   = k_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_fft_input_reorder.sv
// tb_fft_input_reorder: directed frames against a frame-level
// model of bit-reversed pairing, plus literal spot checks.
module tb_fft_input_reorder;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int DW    = 24;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic              pair_valid;
  logic              pair_ready = 1'b0;
  logic [DW-1:0]     pair_a;
  logic [DW-1:0]     pair_b;
  logic [LOG2N-2:0]  pair_idx;
  logic              frame_done;

  fft_input_reorder #(
    .N(N), .LOG2N(LOG2N), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .pair_a(pair_a),
    .pair_b(pair_b),
    .pair_idx(pair_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            idx;
  } pair_t;

  pair_t         exp_q[$];
  logic [DW-1:0] frame_buf[$];

  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_a, hold_b;
  int            hold_idx;
  bit            exp_fd = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++)
      if (((v >> i) & 1) != 0)
        r = r | (1 << (LOG2N - 1 - i));
    return r;
  endfunction

  // Frame-level model: x[n] lands in slot brev(n), so pair k
  // carries x[brev(2k)] and x[brev(2k+1)].
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      frame_buf.delete();
      hold_v = 1'b0;
      exp_fd = 1'b0;
    end else begin
      check("frame_done", frame_done, exp_fd);
      exp_fd = 1'b0;
      check("no_overlap", pair_valid && in_ready, 0);
      if (hold_v) begin
        check("hold_valid", pair_valid, 1);
        check("hold_a", pair_a, hold_a);
        check("hold_b", pair_b, hold_b);
        check("hold_idx", pair_idx, hold_idx);
      end
      hold_v = 1'b0;
      if (pair_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pair_unexpected: got a=%h b=%h none due",
                   pair_a, pair_b);
        end else begin
          check("pair_a", pair_a, exp_q[0].a);
          check("pair_b", pair_b, exp_q[0].b);
          check("pair_idx", pair_idx, exp_q[0].idx);
          if (pair_ready) begin
            if (exp_q[0].idx == N/2 - 1) exp_fd = 1'b1;
            void'(exp_q.pop_front());
          end else begin
            hold_v   = 1'b1;
            hold_a   = pair_a;
            hold_b   = pair_b;
            hold_idx = int'(pair_idx);
          end
        end
      end
      if (in_valid && in_ready) begin
        frame_buf.push_back(in_data);
        if (frame_buf.size() == N) begin
          for (int k = 0; k < N/2; k++) begin
            pair_t p;
            p.a   = frame_buf[brev(2*k)];
            p.b   = frame_buf[brev(2*k+1)];
            p.idx = k;
            exp_q.push_back(p);
          end
          frame_buf.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] x, input bit gap);
    int t = 0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    check("in_ready_wait", in_ready, 1);
    tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] xs [N],
                            input bit gap);
    for (int i = 0; i < N; i++) send(xs[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!frame_done && t < 50) begin
      tick();
      t++;
    end
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic check_reset_outs();
    check("rst_in_ready", in_ready, 0);
    check("rst_pair_valid", pair_valid, 0);
    check("rst_pair_a", pair_a, 0);
    check("rst_pair_b", pair_b, 0);
    check("rst_pair_idx", pair_idx, 0);
    check("rst_frame_done", frame_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] f1 [N];
    logic [DW-1:0] f2 [N];
    logic [DW-1:0] f3 [N];
    logic [DW-1:0] f4 [N];
    logic [DW-1:0] lit_a [4];
    logic [DW-1:0] lit_b [4];

    for (int i = 0; i < N; i++) begin
      f1[i] = DW'((i + 1) * 'h001001);
      f2[i] = DW'('h0A0B00 + i * 'h000011);
      f3[i] = DW'('h300300 + i * 'h010010);
    end
    f2[0] = 24'h7FF800;
    f4 = '{24'h800800, 24'h7FF7FF, 24'h000000, 24'hFFFFFF,
           24'h123456, 24'hABCDEF, 24'h000000, 24'hFFFFFF};
    lit_a = '{24'h001001, 24'h003003, 24'h002002, 24'h004004};
    lit_b = '{24'h005005, 24'h007007, 24'h006006, 24'h008008};

    // Reset values, then in_ready one edge after release.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_reset_outs();
    reset_n = 1'b1;
    #1;
    check("in_ready_pre_edge", in_ready, 0);
    tick();
    check("in_ready_post_edge", in_ready, 1);

    // Basic frame.
    pair_ready = 1'b1;
    send_frame(f1, 1'b0);
    check("basic_in_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      check("basic_valid", pair_valid, 1);
      check("basic_a", pair_a, lit_a[k]);
      check("basic_b", pair_b, lit_b[k]);
      check("basic_idx", pair_idx, k);
    end
    tick();
    check("basic_done", frame_done, 1);
    check("basic_valid_off", pair_valid, 0);
    check("basic_ready_on", in_ready, 1);
    tick();
    check("basic_done_off", frame_done, 0);

    // Backpressure at k=1 with garbage on the input.
    pair_ready = 1'b0;
    send_frame(f1, 1'b0);
    tick();
    pair_ready = 1'b1;
    tick();
    pair_ready = 1'b0;
    in_valid   = 1'b1;
    in_data    = 24'hFFFFFF;
    repeat (5) begin
      check("bp_valid", pair_valid, 1);
      check("bp_a", pair_a, 24'h003003);
      check("bp_b", pair_b, 24'h007007);
      check("bp_idx", pair_idx, 1);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid   = 1'b0;
    pair_ready = 1'b1;
    wait_done();

    // Input gaps during fill.
    send_frame(f1, 1'b1);
    wait_done();

    // Back-to-back: next frame starts in the frame_done cycle.
    send_frame(f1, 1'b0);
    wait_done();
    check("b2b_ready", in_ready, 1);
    send_frame(f2, 1'b0);
    check("b2b_pair0_a", pair_a, 24'h7FF800);
    wait_done();

    // Reset mid-fill.
    tick();
    for (int i = 0; i < 5; i++) send(f1[i], 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_reset_outs();
    repeat (2) @(posedge clk);
    #4;
    reset_n = 1'b1;
    tick();
    send_frame(f3, 1'b0);
    check("rst_new_a", pair_a, f3[0]);
    check("rst_new_b", pair_b, f3[4]);
    wait_done();

    // Extreme values.
    send_frame(f4, 1'b0);
    check("ext_pair0_a", pair_a, 24'h800800);
    check("ext_pair0_b", pair_b, 24'h123456);
    tick();
    check("ext_pair1_a", pair_a, 24'h000000);
    tick();
    check("ext_pair2_a", pair_a, 24'h7FF7FF);
    check("ext_pair2_b", pair_b, 24'hABCDEF);
    tick();
    check("ext_pair3_a", pair_a, 24'hFFFFFF);
    check("ext_pair3_b", pair_b, 24'hFFFFFF);
    wait_done();

    tick();
    tick();
    check("model_drained", exp_q.size() + frame_buf.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
